// File: rtl/mux_nlut_reg_pkg.sv
// Shared definitions for the mux_nlut_reg wide-mux BEL: config bit indices, config width, 2:1 mux cell.
// Optional feature macro: MUX_NLUT_SYNC_SR_EN (adds SR port and cfg_srval config bit).
package mux_nlut_reg_pkg;

  localparam int K_MIN = 3;
  localparam int K_MAX = 5;

  function automatic int reg_m_idx(input int l);
    return l;
  endfunction

  function automatic int reg_mh_idx(input int k, input int l);
    return k + l;
  endfunction

  function automatic int ce_idx(input int k);
    return 2 * k - 1;
  endfunction

  function automatic int selreg_idx(input int k);
    return 2 * k;
  endfunction

  function automatic int srval_idx(input int k);
    return 2 * k + 1;
  endfunction

  function automatic int no_config_bits(input int k);
`ifdef MUX_NLUT_SYNC_SR_EN
    return 2 * k + 2;
`else
    return 2 * k + 1;
`endif
  endfunction

  // Primitive 2:1 cell used for every node of the select tree.
  function automatic logic cus_mux21(input logic a0, input logic a1, input logic s);
    return s ? a1 : a0;
  endfunction

endpackage

// File: rtl/mux_nlut_reg_level.sv
// One level of the select tree: IN_W inputs reduced to IN_W/2 nodes by a shared select.
module mux_nlut_reg_level
  import mux_nlut_reg_pkg::*;
#(
  parameter int IN_W = 16
) (
  input  logic [IN_W-1:0]   d_i,
  input  logic              s_i,
  output logic [IN_W/2-1:0] y_o
);

  for (genvar j = 0; j < IN_W / 2; j++) begin : g_node
    assign y_o[j] = cus_mux21(d_i[2*j], d_i[2*j+1], s_i);
  end

endmodule

// File: rtl/mux_nlut_reg.sv
// Parametrised 2^K:1 wide-mux BEL exposing every tree level, each output optionally registered.
// BelMap config order: reg_m[K-1:0], reg_mh[K-2:0], cfg_ce, cfg_selreg, cfg_srval (MUX_NLUT_SYNC_SR_EN).
module mux_nlut_reg
  import mux_nlut_reg_pkg::*;
#(
  parameter int K            = 4,
  parameter int NoConfigBits = no_config_bits(K)
) (
  input  logic                    UserCLK,
  input  logic                    UserRSTn,
  input  logic [2**K-1:0]         I,
  input  logic [K-1:0]            S,
  input  logic                    CE,
`ifdef MUX_NLUT_SYNC_SR_EN
  input  logic                    SR,
`endif
  output logic [K-1:0]            M,
  output logic [K-2:0]            MH,
  input  logic [NoConfigBits-1:0] ConfigBits
);

  localparam int N = 2 ** K;

  logic [K-1:0] reg_m;
  logic [K-2:0] reg_mh;
  logic         cfg_ce;
  logic         cfg_selreg;
  logic         en;
  logic [K-1:0] s_eff;
  logic [K-1:0] s_q;
  logic [K-1:0] m_d, m_q;
  logic [K-2:0] mh_d, mh_q;
  // Level l occupies tree[N-2^(K-l) +: 2^(K-l-1)]; the root is tree[N-2].
  logic [N-2:0] tree;

  assign reg_m      = ConfigBits[reg_m_idx(K-1):reg_m_idx(0)];
  assign reg_mh     = ConfigBits[reg_mh_idx(K, K-2):reg_mh_idx(K, 0)];
  assign cfg_ce     = ConfigBits[ce_idx(K)];
  assign cfg_selreg = ConfigBits[selreg_idx(K)];
  assign en         = ~cfg_ce | CE;
  assign s_eff      = cfg_selreg ? s_q : S;

  for (genvar l = 0; l < K; l++) begin : g_lvl
    if (l == 0) begin : g_leaf
      mux_nlut_reg_level #(.IN_W(N)) u_level (
        .d_i (I),
        .s_i (s_eff[0]),
        .y_o (tree[0 +: N/2])
      );
    end else begin : g_inner
      mux_nlut_reg_level #(.IN_W(2**(K-l))) u_level (
        .d_i (tree[N-2**(K-l+1) +: 2**(K-l)]),
        .s_i (s_eff[l]),
        .y_o (tree[N-2**(K-l) +: 2**(K-l-1)])
      );
    end
    assign m_d[l] = tree[N-2**(K-l)];
    assign M[l]   = cus_mux21(m_d[l], m_q[l], reg_m[l]);
    if (l < K - 1) begin : g_high
      assign mh_d[l] = tree[N-2**(K-l)+2**(K-l-1)-1];
      assign MH[l]   = cus_mux21(mh_d[l], mh_q[l], reg_mh[l]);
    end
  end

`ifdef MUX_NLUT_SYNC_SR_EN
  logic cfg_srval;
  assign cfg_srval = ConfigBits[srval_idx(K)];
`endif

  // SR beats CE; async reset beats everything.
  always_ff @(posedge UserCLK or negedge UserRSTn) begin
    if (!UserRSTn) begin
      m_q  <= '0;
      mh_q <= '0;
      s_q  <= '0;
`ifdef MUX_NLUT_SYNC_SR_EN
    end else if (SR) begin
      m_q  <= {K{cfg_srval}};
      mh_q <= {(K-1){cfg_srval}};
      s_q  <= '0;
`endif
    end else if (en) begin
      m_q  <= m_d;
      mh_q <= mh_d;
      s_q  <= S;
    end
  end

endmodule

// File: tb/tb_mux_nlut_reg.sv
// Scoreboard bench for mux_nlut_reg at K=4 (SR tests only when MUX_NLUT_SYNC_SR_EN is defined).
module tb_mux_nlut_reg;

`ifdef MUX_NLUT_SYNC_SR_EN
  localparam int NCB = 10;
`else
  localparam int NCB = 9;
`endif

  logic           UserCLK;
  logic           UserRSTn;
  logic [15:0]    I;
  logic [3:0]     S;
  logic           CE;
  logic           SR;
  logic [3:0]     M;
  logic [2:0]     MH;
  logic [NCB-1:0] cfg;

  int n_cmp = 0;
  int n_bad = 0;

  logic [6:0] exp_q[$];
  logic [3:0] mq, sq;
  logic [2:0] mhq;

  mux_nlut_reg #(.K(4)) dut (
    .UserCLK    (UserCLK),
    .UserRSTn   (UserRSTn),
    .I          (I),
    .S          (S),
    .CE         (CE),
`ifdef MUX_NLUT_SYNC_SR_EN
    .SR         (SR),
`endif
    .M          (M),
    .MH         (MH),
    .ConfigBits (cfg)
  );

  initial begin
    UserCLK = 1'b0;
    forever #5 UserCLK = ~UserCLK;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Lowest node at level l picks I[S mod 2^(l+1)]; highest picks from the top 2^(l+1) inputs.
  function automatic logic [3:0] node_m(input logic [15:0] i, input logic [3:0] s);
    logic [3:0] r;
    for (int l = 0; l < 4; l++) r[l] = i[int'(s) & ((2 << l) - 1)];
    return r;
  endfunction

  function automatic logic [2:0] node_mh(input logic [15:0] i, input logic [3:0] s);
    logic [2:0] r;
    for (int l = 0; l < 3; l++) r[l] = i[16 - (2 << l) + (int'(s) & ((2 << l) - 1))];
    return r;
  endfunction

  function automatic logic [3:0] s_eff();
    return cfg[8] ? sq : S;
  endfunction

  function automatic logic srval();
`ifdef MUX_NLUT_SYNC_SR_EN
    return cfg[9];
`else
    return 1'b0;
`endif
  endfunction

  task automatic push_expect();
    logic [3:0] nm, em;
    logic [2:0] nh, eh;
    nm = node_m(I, s_eff());
    nh = node_mh(I, s_eff());
    for (int l = 0; l < 4; l++) em[l] = cfg[l] ? mq[l] : nm[l];
    for (int l = 0; l < 3; l++) eh[l] = cfg[4+l] ? mhq[l] : nh[l];
    exp_q.push_back({em, eh});
  endtask

  task automatic pop_check(input string tag);
    logic [6:0] e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: scoreboard empty, got %0h", tag, {M, MH});
    end else begin
      e = exp_q.pop_front();
      chk({tag, ".M"}, 32'(M), 32'(e[6:3]));
      chk({tag, ".MH"}, 32'(MH), 32'(e[2:0]));
    end
  endtask

  task automatic model_edge();
    logic [3:0] se;
    se = s_eff();
    if (!UserRSTn) begin
      mq = '0; mhq = '0; sq = '0;
    end else if (SR) begin
      mq = {4{srval()}}; mhq = {3{srval()}}; sq = '0;
    end else if (!cfg[7] || CE) begin
      mq = node_m(I, se); mhq = node_mh(I, se); sq = S;
    end
  endtask

  task automatic step(input string tag, input logic [15:0] i, input logic [3:0] s, input logic ce_v);
    I = i; S = s; CE = ce_v;
    #1;
    push_expect();
    @(negedge UserCLK);
    pop_check(tag);
    @(posedge UserCLK);
    model_edge();
    #1;
  endtask

  initial begin
    mq = '0; mhq = '0; sq = '0;
    UserRSTn = 1'b0; SR = 1'b0; CE = 1'b1; I = 16'hFFFF; S = '0;
    cfg = '0; cfg[6:0] = 7'h7F;
    #2;
    push_expect();
    pop_check("reset");
    @(posedge UserCLK);
    model_edge();
    #1;
    UserRSTn = 1'b1;

    // T1: fully combinational sweep
    cfg = '0;
    for (int s = 0; s < 16; s++) step("t1_sweep", 16'hA5C3, 4'(s), 1'b1);

    // T2: registered root
    cfg = '0; cfg[3] = 1'b1;
    step("t2_s0", 16'h0001, 4'd0, 1'b1);
    step("t2_s1", 16'h0001, 4'd1, 1'b1);
    step("t2_hold", 16'h0001, 4'd1, 1'b1);

    // T3: registered select, combinational outputs
    cfg = '0; cfg[8] = 1'b1;
    step("t3_s0", 16'h0020, 4'd0, 1'b1);
    step("t3_s5", 16'h0020, 4'd5, 1'b1);
    step("t3_after", 16'h0020, 4'd5, 1'b1);

    // T4: clock enable freezes registered outputs
    cfg = '0; cfg[6:0] = 7'h7F; cfg[7] = 1'b1;
    step("t4_load", 16'hFFFF, 4'd3, 1'b1);
    step("t4_ce0a", 16'h0000, 4'd3, 1'b0);
    step("t4_ce0b", 16'hFFFF, 4'd3, 1'b0);
    step("t4_ce0c", 16'h0000, 4'd3, 1'b0);
    step("t4_ce1", 16'h0000, 4'd3, 1'b1);
    step("t4_upd", 16'h0000, 4'd3, 1'b1);

    // T5: asynchronous reset mid-cycle
    cfg = '0; cfg[6:0] = 7'h7F;
    step("t5_fill", 16'hFFFF, 4'd9, 1'b1);
    step("t5_ones", 16'hFFFF, 4'd9, 1'b1);
    UserRSTn = 1'b0;
    #1;
    mq = '0; mhq = '0; sq = '0;
    push_expect();
    pop_check("t5_async");
    @(posedge UserCLK);
    model_edge();
    #1;
    UserRSTn = 1'b1;
    step("t5_rel", 16'hFFFF, 4'd9, 1'b1);
    step("t5_resume", 16'hFFFF, 4'd9, 1'b1);

`ifdef MUX_NLUT_SYNC_SR_EN
    // T6: synchronous set overrides CE, async reset overrides SR
    cfg = '0; cfg[6:0] = 7'h7F; cfg[7] = 1'b1; cfg[9] = 1'b1;
    step("t6_clr", 16'h0000, 4'd0, 1'b1);
    SR = 1'b1;
    step("t6_sr", 16'h0000, 4'd0, 1'b0);
    SR = 1'b0;
    step("t6_set", 16'h0000, 4'd0, 1'b0);
    SR = 1'b1;
    UserRSTn = 1'b0;
    #1;
    mq = '0; mhq = '0; sq = '0;
    push_expect();
    pop_check("t6_rst");
    @(posedge UserCLK);
    model_edge();
    #1;
    SR = 1'b0;
    UserRSTn = 1'b1;
`endif

    // Random config, data and select mix
    for (int n = 0; n < 40; n++) begin
      cfg = NCB'($urandom);
      step("rand", 16'($urandom), 4'($urandom), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
